// File: rtl/miniscope_pkg.sv
// miniscope_pkg: shared definitions for the multi-channel miniscope.
// The parity option is enabled by the MINISCOPE_PARITY_EN macro in the files that use it.
package miniscope_pkg;

    localparam int unsigned NCH_DEFAULT   = 2;
    localparam int unsigned WIDTH_DEFAULT = 8;
    localparam int unsigned ADRB_DEFAULT  = 11;

    // Readout sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain
    } rd_state_e;

    // Stored parity bit: the XNOR of the data, so each word plus its parity bit has odd weight.
    // Callers zero-extend to 64 bits, which leaves the reduction unchanged.
    function automatic logic parity_bit(input logic [63:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/miniscope_ram.sv
// miniscope_ram: one channel of simple dual-port RAM.
// Port A writes, port B reads with one registered cycle of latency. A read of the address
// being written in the same cycle returns the old contents (read-first).
module miniscope_ram #(
    parameter int unsigned DW = 9,
    parameter int unsigned AW = 11
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_adr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_adr,
    output logic [DW-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;

    // Write port; contents are deliberately left untouched by reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_adr] <= wr_data;
        end
    end

    // Registered read port; holds its value between reads
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_adr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/miniscope_multi.sv
// miniscope_multi: multi-channel circular capture buffer with look-back readout.
// Define MINISCOPE_PARITY_EN to store a parity bit per channel and drive the error outputs;
// without it, the error outputs are tied to zero.
module miniscope_multi
    import miniscope_pkg::*;
#(
    parameter int unsigned NCH   = NCH_DEFAULT,
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned ADRB  = ADRB_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [NCH*WIDTH-1:0] wdata,
    input  logic                 test_mode,
    input  logic                 rd_start,
    input  logic [ADRB-1:0]      rd_offset,
    input  logic [ADRB-1:0]      rd_tbins,
    output logic [ADRB-1:0]      wadr,
    output logic                 rd_busy,
    output logic                 rd_valid,
    output logic                 rd_last,
    output logic [NCH*WIDTH-1:0] rd_data,
    output logic [NCH-1:0]       parity_err,
    output logic [NCH-1:0]       parity_err_sticky,
    output logic [7:0]           err_cnt
);

`ifdef MINISCOPE_PARITY_EN
    localparam int unsigned RAM_W = WIDTH + 1;
`else
    localparam int unsigned RAM_W = WIDTH;
`endif

    logic [ADRB-1:0]      wadr_q;
    logic                 test_mode_q;
    logic                 wr_go;
    rd_state_e            state_q;
    logic [ADRB-1:0]      radr_q;
    logic [ADRB-1:0]      remain_q;
    logic                 rd_busy_q;
    logic                 accept;
    logic                 iss_en;
    logic                 iss_last;
    logic [ADRB-1:0]      iss_adr;
    logic                 v1_q;
    logic                 last1_q;
    logic                 rd_valid_q;
    logic                 rd_last_q;
    logic [NCH*WIDTH-1:0] rd_data_q;
    logic [NCH*WIDTH-1:0] ram_data1;

    assign wr_go = wr_en & ~reset;

    // Write pointer and registered test-mode select
    always_ff @(posedge clock) begin
        if (reset) begin
            wadr_q      <= '0;
            test_mode_q <= 1'b0;
        end else begin
            test_mode_q <= test_mode;
            if (wr_en) begin
                wadr_q <= wadr_q + ADRB'(1);
            end
        end
    end

    // Read issue: the first address goes out in the accepting cycle, the rest from StRead
    always_comb begin
        accept   = (state_q == StIdle) && !rd_busy_q && rd_start && (rd_tbins != '0);
        iss_en   = 1'b0;
        iss_adr  = radr_q;
        iss_last = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    iss_en   = 1'b1;
                    iss_adr  = wadr_q - rd_offset;
                    iss_last = (rd_tbins == ADRB'(1));
                end
            end
            StRead: begin
                iss_en   = 1'b1;
                iss_last = (remain_q == ADRB'(1));
            end
            default: ;
        endcase
    end

    // Readout sequencer and busy flag (busy holds through the rd_last cycle)
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            radr_q    <= '0;
            remain_q  <= '0;
            rd_busy_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        radr_q   <= iss_adr + ADRB'(1);
                        remain_q <= rd_tbins - ADRB'(1);
                        state_q  <= (rd_tbins == ADRB'(1)) ? StDrain : StRead;
                    end
                end
                StRead: begin
                    radr_q   <= radr_q + ADRB'(1);
                    remain_q <= remain_q - ADRB'(1);
                    if (remain_q == ADRB'(1)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (accept) begin
                rd_busy_q <= 1'b1;
            end else if (rd_last_q) begin
                rd_busy_q <= 1'b0;
            end
        end
    end

`ifdef MINISCOPE_PARITY_EN
    logic [NCH-1:0] perr1;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [WIDTH-1:0] wr_word;
        logic [RAM_W-1:0] ram_wr;
        logic [RAM_W-1:0] ram_rd;

        // Test pattern is the write address offset by the channel number
        always_comb begin
            wr_word = test_mode_q ? WIDTH'(32'(wadr_q) + 32'(c)) : wdata[c*WIDTH +: WIDTH];
        end

`ifdef MINISCOPE_PARITY_EN
        assign ram_wr   = {parity_bit(64'(wr_word)), wr_word};
        assign perr1[c] = parity_bit(64'(ram_rd[WIDTH-1:0])) != ram_rd[WIDTH];
`else
        assign ram_wr = wr_word;
`endif
        assign ram_data1[c*WIDTH +: WIDTH] = ram_rd[WIDTH-1:0];

        miniscope_ram #(
            .DW(RAM_W),
            .AW(ADRB)
        ) u_ram (
            .clock  (clock),
            .wr_en  (wr_go),
            .wr_adr (wadr_q),
            .wr_data(ram_wr),
            .rd_en  (iss_en),
            .rd_adr (iss_adr),
            .rd_data(ram_rd)
        );
    end

    // Output pipeline: RAM stage then registered output stage
    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q       <= 1'b0;
            last1_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            v1_q       <= iss_en;
            last1_q    <= iss_en & iss_last;
            rd_valid_q <= v1_q;
            rd_last_q  <= last1_q;
            if (v1_q) begin
                rd_data_q <= ram_data1;
            end
        end
    end

`ifdef MINISCOPE_PARITY_EN
    logic [NCH-1:0] perr_q;
    logic [NCH-1:0] sticky_q;
    logic [7:0]     cnt_q;

    // Parity check on each read word, with sticky flags and a saturating word count
    always_ff @(posedge clock) begin
        if (reset) begin
            perr_q   <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            perr_q <= v1_q ? perr1 : '0;
            if (v1_q) begin
                sticky_q <= sticky_q | perr1;
                if ((|perr1) && (cnt_q != 8'hff)) begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    assign parity_err        = perr_q;
    assign parity_err_sticky = sticky_q;
    assign err_cnt           = cnt_q;
`else
    assign parity_err        = '0;
    assign parity_err_sticky = '0;
    assign err_cnt           = '0;
`endif

    assign wadr     = wadr_q;
    assign rd_busy  = rd_busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_miniscope_multi.sv
// tb_miniscope_multi: scoreboard bench for miniscope_multi.
// The driver keeps an address-indexed memory model; each readout word is taken from it in the
// cycle its address is read (word k of a readout started in cycle N is read in cycle N+k,
// before that cycle's write) and is expected on the outputs two cycles later.
module tb_miniscope_multi;

    localparam int NCH   = 2;
    localparam int WIDTH = 8;
    localparam int ADRB  = 11;
    localparam int DEPTH = 2 ** ADRB;
    localparam int DW    = NCH * WIDTH;

    logic            clock = 1'b0;
    logic            reset;
    logic            wr_en;
    logic [DW-1:0]   wdata;
    logic            test_mode;
    logic            rd_start;
    logic [ADRB-1:0] rd_offset;
    logic [ADRB-1:0] rd_tbins;
    logic [ADRB-1:0] wadr;
    logic            rd_busy;
    logic            rd_valid;
    logic            rd_last;
    logic [DW-1:0]   rd_data;
    logic [NCH-1:0]  parity_err;
    logic [NCH-1:0]  parity_err_sticky;
    logic [7:0]      err_cnt;

    miniscope_multi #(
        .NCH  (NCH),
        .WIDTH(WIDTH),
        .ADRB (ADRB)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .wr_en            (wr_en),
        .wdata            (wdata),
        .test_mode        (test_mode),
        .rd_start         (rd_start),
        .rd_offset        (rd_offset),
        .rd_tbins         (rd_tbins),
        .wadr             (wadr),
        .rd_busy          (rd_busy),
        .rd_valid         (rd_valid),
        .rd_last          (rd_last),
        .rd_data          (rd_data),
        .parity_err       (parity_err),
        .parity_err_sticky(parity_err_sticky),
        .err_cnt          (err_cnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0]  data;
        logic           last;
        logic [NCH-1:0] perr;
        int             cyc;
    } exp_t;

    logic [DW-1:0]  mem_m [DEPTH];
    logic [NCH-1:0] bad_m [DEPTH];
    int             m_wadr = 0;
    logic           tm_m = 1'b0;
    int             pend_q[$];
    exp_t           exp_q[$];
    int             busy_lo = 1;
    int             busy_hi = 0;
    logic           live = 1'b0;
    int             checks = 0;
    int             errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock cycle of stimulus plus the matching reference-model update
    task automatic step(input logic wr, input logic [DW-1:0] wd, input logic tm, input logic rs,
                        input int off, input int tb, input logic rst);
        int   n;
        int   a;
        exp_t e;
        n = cyc;
        if (live) check("wadr", 64'(wadr), 64'(m_wadr));
        reset     = rst;
        wr_en     = wr;
        wdata     = wd;
        test_mode = tm;
        rd_start  = rs;
        rd_offset = ADRB'(off);
        rd_tbins  = ADRB'(tb);
        if (rst) begin
            pend_q.delete();
            if (busy_hi > n) busy_hi = n;
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > n) void'(exp_q.pop_back());
            m_wadr = 0;
            tm_m   = 1'b0;
        end else begin
            if (rs && tb != 0 && !(n >= busy_lo && n <= busy_hi)) begin
                a = (m_wadr - off + DEPTH) % DEPTH;
                for (int k = 0; k < tb; k++) pend_q.push_back((a + k) % DEPTH);
                busy_lo = n + 1;
                busy_hi = n + tb + 1;
            end
            if (pend_q.size() > 0) begin
                a      = pend_q.pop_front();
                e.data = mem_m[a];
                e.perr = bad_m[a];
                e.last = (pend_q.size() == 0);
                e.cyc  = n + 2;
                exp_q.push_back(e);
            end
            if (wr) begin
                for (int c = 0; c < NCH; c++)
                    mem_m[m_wadr][c*WIDTH +: WIDTH] = tm_m ? WIDTH'(m_wadr + c)
                                                           : wd[c*WIDTH +: WIDTH];
                bad_m[m_wadr] = '0;
                m_wadr = (m_wadr + 1) % DEPTH;
            end
            tm_m = tm;
        end
        @(posedge clock);
        #1;
        if (rst) live = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic start_rd(input int off, input int tb);
        step(1'b0, '0, 1'b0, 1'b1, off, tb, 1'b0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a word
    logic [DW-1:0]  hold_m   = '0;
    logic [NCH-1:0] sticky_m = '0;
    int             cnt_m    = 0;
    always @(negedge clock) begin
        int   n;
        exp_t e;
        if (live) begin
            n = cyc;
            check("rd_busy", 64'(rd_busy), 64'(n >= busy_lo && n <= busy_hi));
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious rd_valid", 64'(rd_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    if (e.perr != '0 && cnt_m < 255) cnt_m++;
                    sticky_m = sticky_m | e.perr;
                    hold_m   = e.data;
                    check("word cycle", 64'(n), 64'(e.cyc));
                    check("rd_data", 64'(rd_data), 64'(e.data));
                    check("rd_last", 64'(rd_last), 64'(e.last));
                    check("parity_err", 64'(parity_err), 64'(e.perr));
                end
            end else begin
                check("rd_last idle", 64'(rd_last), 64'(0));
                check("parity_err idle", 64'(parity_err), 64'(0));
                check("rd_data held", 64'(rd_data), 64'(hold_m));
                if (exp_q.size() > 0 && exp_q[0].cyc <= n) begin
                    check("missing word", 64'(rd_valid), 64'(1));
                    void'(exp_q.pop_front());
                end
            end
            check("parity_err_sticky", 64'(parity_err_sticky), 64'(sticky_m));
            check("err_cnt", 64'(err_cnt), 64'(cnt_m));
            if (reset) begin
                hold_m   = '0;
                sticky_m = '0;
                cnt_m    = 0;
            end
        end
    end

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            mem_m[a] = '0;
            bad_m[a] = '0;
        end
        reset = 1'b1; wr_en = 1'b0; wdata = '0; test_mode = 1'b0;
        rd_start = 1'b0; rd_offset = '0; rd_tbins = '0;
        @(posedge clock);
        #1;
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 0, 0, 1'b1);
        check("reset state",
              64'({rd_busy, rd_valid, rd_last, parity_err, parity_err_sticky, err_cnt,
                   rd_data, wadr}), 64'(0));

        // Address test pattern: 20 writes, then read them all back
        step(1'b0, '0, 1'b1, 1'b0, 0, 0, 1'b0);
        repeat (20) step(1'b1, DW'($urandom), 1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 0, 0, 1'b0);
        check("wadr after 20 writes", 64'(wadr), 64'(20));
        start_rd(20, 20);
        idle(25);

        // Fill the whole memory with random data
        repeat (DEPTH) step(1'b1, DW'($urandom), 1'b0, 1'b0, 0, 0, 1'b0);

        // Wrapping look-back, a second start while busy, then a zero-length request
        step(1'b0, '0, 1'b0, 1'b0, 0, 0, 1'b1);
        repeat (5) step(1'b1, DW'($urandom), 1'b0, 1'b0, 0, 0, 1'b0);
        start_rd(8, 4);
        idle(2);
        start_rd(8, 4);
        idle(6);
        start_rd(3, 0);
        idle(4);

        // Offset 0 with continuous writes: every read must see the pre-write data
        step(1'b1, DW'($urandom), 1'b0, 1'b1, 0, 16, 1'b0);
        repeat (20) step(1'b1, DW'($urandom), 1'b0, 1'b0, 0, 0, 1'b0);
        idle(4);

        // Reset in the middle of an 8-word readout, then a normal readout
        start_rd(30, 8);
        idle(2);
        step(1'b0, '0, 1'b0, 1'b0, 0, 0, 1'b1);
        idle(4);
        start_rd(10, 5);
        idle(10);

        // Randomized traffic
        repeat (500) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0), int'($urandom_range(0, DEPTH - 1)),
                 int'($urandom_range(0, 24)), ($urandom_range(0, 199) == 0));
        end
        idle(30);

`ifdef MINISCOPE_PARITY_EN
        // Corrupt channel 1 parity at address 3, then at 299 more addresses
        dut.g_ch[1].u_ram.mem[3][WIDTH] = ~dut.g_ch[1].u_ram.mem[3][WIDTH];
        bad_m[3][1] = ~bad_m[3][1];
        start_rd((m_wadr - 3 + DEPTH) % DEPTH, 1);
        idle(6);
        for (int a = 100; a < 399; a++) begin
            dut.g_ch[1].u_ram.mem[a][WIDTH] = ~dut.g_ch[1].u_ram.mem[a][WIDTH];
            bad_m[a][1] = ~bad_m[a][1];
        end
        start_rd((m_wadr - 100 + DEPTH) % DEPTH, 299);
        idle(305);
        check("err_cnt saturated", 64'(err_cnt), 64'(255));
`endif

        idle(10);
        check("scoreboard drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/miniscope_multi.md
MINISCOPE_MULTI -- requirements
Module: miniscope_multi

Interface
REQ-001 Parameter NCH, default 2: number of independent byte-lane channels.
REQ-002 Parameter WIDTH, default 8: data bits per channel.
REQ-003 Parameter ADRB, default 11: address width; depth = 2**ADRB.
REQ-004 clock  in  1  TMB 40MHz main; sole clock.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 wr_en  in  1  1 = store wdata at wadr, then advance wadr.
REQ-007 wdata  in  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
REQ-008 test_mode  in  1  1 = replace wdata with the address test pattern.
REQ-009 rd_start  in  1  single-cycle pulse requesting a readout.
REQ-010 rd_offset  in  ADRB  look-back distance from current wadr.
REQ-011 rd_tbins  in  ADRB  number of words to read out.
REQ-012 wadr  out  ADRB  current write pointer.
REQ-013 rd_busy  out  1  readout in progress.
REQ-014 rd_valid  out  1  rd_data holds a valid word.
REQ-015 rd_last  out  1  final word of the readout, coincident with rd_valid.
REQ-016 rd_data  out  NCH*WIDTH  read word.
REQ-017 parity_err  out  NCH  per-channel parity mismatch on the current rd_valid word.
REQ-018 parity_err_sticky  out  NCH  latched OR of parity_err since reset.
REQ-019 err_cnt  out  8  count of words with any parity_err, saturating at 255.

Function
REQ-020 Each wr_en cycle writes all channels at wadr; wadr increments mod 2**ADRB and wraps 2**ADRB-1 -> 0.
REQ-021 test_mode is registered once; while the registered value is 1, channel c writes (wadr + c) mod 2**WIDTH.
REQ-022 FSM states: IDLE, READ, DRAIN.
REQ-023 IDLE: rd_start with rd_tbins != 0 latches start = (wadr - rd_offset) mod 2**ADRB and count = rd_tbins, then enters READ; rd_start with rd_tbins == 0 is ignored.
REQ-024 READ: one read address per cycle, start, start+1, ..., wrapping mod depth; enter DRAIN after count addresses have been issued.
REQ-025 DRAIN: lasts one cycle, then returns to IDLE.
REQ-026 Latency: a rd_start in cycle N gives word 0 with rd_valid in cycle N+2; words follow on consecutive cycles with no gaps; rd_last is set on word rd_tbins-1.
REQ-027 rd_busy is high from N+1 through the rd_last cycle inclusive.
REQ-028 rd_start while rd_busy is ignored.
REQ-029 rd_valid, rd_last, parity_err and rd_data are registered; rd_data is held when rd_valid = 0.
REQ-030 Writes continue during readout.
REQ-031 On a same-cycle read/write to the same address, the read returns the old data (read-first).
REQ-032 parity_err is evaluated only when rd_valid = 1 and is 0 otherwise.
REQ-033 err_cnt increments by one per word with any bit of parity_err set.

Reset
REQ-034 Reset sets wadr = 0, state = IDLE, and rd_busy, rd_valid, rd_last, rd_data, parity_err, parity_err_sticky and err_cnt all to 0.
REQ-035 RAM contents are not cleared by reset.
REQ-036 Reset mid-readout aborts it in the next cycle; no rd_last is issued.

Configuration
REQ-037 Macro MINISCOPE_PARITY_EN defined: each channel stores one parity bit = ~^data beside its data word, and the read-side check drives parity_err, parity_err_sticky and err_cnt.
REQ-038 MINISCOPE_PARITY_EN undefined: no parity storage; parity_err, parity_err_sticky and err_cnt are tied to 0.

Structure
REQ-039 Package miniscope_pkg holds the FSM state enum, the default parameter constants and the parity function.
REQ-040 Sub-module miniscope_ram: one channel, WIDTH(+1) bits x 2**ADRB words, simple dual-port (write port A, read port B), one-cycle registered read, read-first; instantiated NCH times by a generate loop.

Verification
REQ-041 Reset, then 20 wr_en cycles with test_mode = 1 -> wadr = 20; a later readout at offset 20, tbins 20 returns channel0 = 0..19 and channel1 = 1..20.
REQ-042 wadr = 5, rd_offset = 8, rd_tbins = 4 -> reads addresses 2045, 2046, 2047, 0; rd_valid at N+2..N+5; rd_last at N+5; rd_busy at N+1..N+5.
REQ-043 rd_start pulsed again at N+3 during a busy readout -> ignored; exactly rd_tbins words produced; rd_tbins = 0 -> rd_busy never asserts.
REQ-044 With MINISCOPE_PARITY_EN, force the stored parity of channel 1 at address 3 -> on reading that word parity_err = 2'b10, parity_err_sticky = 2'b10 thereafter, err_cnt = 1; 300 forced errors -> err_cnt = 255.
REQ-045 reset asserted at N+3 of an 8-word readout -> rd_busy, rd_valid and rd_last are 0 from N+4; no rd_last pulse occurs; the next rd_start behaves normally.
REQ-046 Continuous wr_en while reading with offset 0 at the same address -> read returns the pre-write data.
